// File: rtl/sopc_scope_sys_nios_oci_dct_packer.sv
// ---------------------------------------------------------------------------
// sopc_scope_sys_nios_oci_dct_packer
//
// Packs 2-bit direct-conditional-branch trace codes into a frame of up to
// DCT_DEPTH codes. The first code of a frame ends up in the most significant
// occupied bits. A frame closes when it is full or when a flush arrives. A
// closed frame goes to the downstream trace FIFO over a valid/ready handshake.
//
// Ports
//   clk          : system clock, all logic on the rising edge
//   reset_n      : asynchronous active-low reset
//   trc_on       : trace enable; codes are ignored while low
//   dct_valid    : dct_code is valid this cycle
//   dct_code     : branch trace code
//   flush        : pulse that closes a partial frame
//   ovf_clr      : clears the sticky overflow flag
//   frame_ready  : downstream FIFO accepts the presented frame
//   frame_valid  : frame_buffer / frame_count hold a completed frame
//   frame_buffer : completed frame, right-aligned, first code most significant
//   frame_count  : number of codes in the frame (1..DCT_DEPTH)
//   dct_buffer   : live packing register
//   dct_count    : live code count (0..DCT_DEPTH)
//   dct_ovf      : sticky flag, a code was dropped because live was full
// ---------------------------------------------------------------------------
module sopc_scope_sys_nios_oci_dct_packer #(
    parameter int DCT_DEPTH = 15,
    parameter int CODE_W    = 2,
    parameter int CNT_W     = 4,
    localparam int BUF_W    = DCT_DEPTH * CODE_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              trc_on,
    input  logic              dct_valid,
    input  logic [CODE_W-1:0] dct_code,
    input  logic              flush,
    input  logic              ovf_clr,
    input  logic              frame_ready,
    output logic              frame_valid,
    output logic [BUF_W-1:0]  frame_buffer,
    output logic [CNT_W-1:0]  frame_count,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic              dct_ovf
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DCT_DEPTH);

    // The live state is not stored separately; it is implied by the count
    // and the pending-flush bit. A count of DCT_DEPTH can only persist when
    // the output was stalled, so a full register always means HOLD.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        HOLD  = 2'd2
    } live_state_t;

    logic [BUF_W-1:0] live_buf, live_buf_nxt;
    logic [CNT_W-1:0] live_cnt, live_cnt_nxt;
    logic             flush_pend, flush_pend_nxt;
    logic             ovf, ovf_nxt;
    logic             fv, fv_nxt;
    logic [BUF_W-1:0] fbuf, fbuf_nxt;
    logic [CNT_W-1:0] fcnt, fcnt_nxt;

    live_state_t      live_state;
    logic             accept;
    logic             out_free;
    logic             drop;
    logic [BUF_W-1:0] buf_pk;
    logic [CNT_W-1:0] cnt_pk;
    logic             emit_req;
    logic             emit;

    // State register: live packer, overflow flag and the output frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            live_buf   <= '0;
            live_cnt   <= '0;
            flush_pend <= 1'b0;
            ovf        <= 1'b0;
            fv         <= 1'b0;
            fbuf       <= '0;
            fcnt       <= '0;
        end else begin
            live_buf   <= live_buf_nxt;
            live_cnt   <= live_cnt_nxt;
            flush_pend <= flush_pend_nxt;
            ovf        <= ovf_nxt;
            fv         <= fv_nxt;
            fbuf       <= fbuf_nxt;
            fcnt       <= fcnt_nxt;
        end
    end

    // Next-state logic for the live packer. buf_pk/cnt_pk are the live
    // contents after this cycle's code; a frame is emitted from them so the
    // 15th code or a flush produces the frame on the same edge.
    always_comb begin
        accept   = trc_on & dct_valid;
        out_free = !fv | frame_ready;

        if (flush_pend || (live_cnt == FULL_CNT)) begin
            live_state = HOLD;
        end else if (live_cnt == '0) begin
            live_state = EMPTY;
        end else begin
            live_state = FILL;
        end

        buf_pk = live_buf;
        cnt_pk = live_cnt;
        drop   = 1'b0;
        case (live_state)
            EMPTY, FILL: begin
                if (accept) begin
                    buf_pk = {live_buf[BUF_W-CODE_W-1:0], dct_code};
                    cnt_pk = live_cnt + 1'b1;
                end
            end
            HOLD: begin
                // A pending flush below full still packs incoming codes.
                if (accept) begin
                    if (live_cnt == FULL_CNT) begin
                        drop = 1'b1;
                    end else begin
                        buf_pk = {live_buf[BUF_W-CODE_W-1:0], dct_code};
                        cnt_pk = live_cnt + 1'b1;
                    end
                end
            end
            default: begin
                buf_pk = live_buf;
                cnt_pk = live_cnt;
            end
        endcase

        emit_req = (cnt_pk == FULL_CNT) | ((flush | flush_pend) & (cnt_pk != '0));
        emit     = emit_req & out_free;

        if (emit) begin
            live_buf_nxt   = '0;
            live_cnt_nxt   = '0;
            flush_pend_nxt = 1'b0;
        end else begin
            live_buf_nxt   = buf_pk;
            live_cnt_nxt   = cnt_pk;
            flush_pend_nxt = flush_pend | (emit_req & flush);
        end

        // Setting wins over clearing in the same cycle.
        if (drop) begin
            ovf_nxt = 1'b1;
        end else if (ovf_clr) begin
            ovf_nxt = 1'b0;
        end else begin
            ovf_nxt = ovf;
        end
    end

    // Output frame logic: load on emit, otherwise retire on handshake and
    // hold the fields while stalled.
    always_comb begin
        fv_nxt   = fv;
        fbuf_nxt = fbuf;
        fcnt_nxt = fcnt;
        if (emit) begin
            fv_nxt   = 1'b1;
            fbuf_nxt = buf_pk;
            fcnt_nxt = cnt_pk;
        end else if (fv && frame_ready) begin
            fv_nxt = 1'b0;
        end
    end

    assign frame_valid  = fv;
    assign frame_buffer = fbuf;
    assign frame_count  = fcnt;
    assign dct_buffer   = live_buf;
    assign dct_count    = live_cnt;
    assign dct_ovf      = ovf;

endmodule
